// File: rtl/adau1761_init_sequencer.sv
// ADAU1761 bring-up controller: latches SPI mode, programs and polls the PLL,
// then streams a register table from an external one-cycle-latency ROM.
module adau1761_init_sequencer #(
    parameter int          MAX_BYTES       = 8,
    parameter int          POWERUP_CYCLES  = 1000000,
    parameter logic [47:0] PLL_CONFIG      = 48'h007D000C2301,
    parameter int          PLL_LOCK_BIT    = 1,
    parameter int          LOCK_RETRIES    = 16,
    parameter int          POLL_GAP_CYCLES = 1000,
    parameter int          NUM_REGS        = 32,
    parameter int          START_TIMEOUT   = 64,
    localparam int         NB_W            = $clog2(MAX_BYTES),
    localparam int         IDX_W           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int         DW              = MAX_BYTES * 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [23:0]      tbl_entry,
    output logic             spi_start,
    output logic             spi_read,
    output logic [NB_W-1:0]  spi_nbytes,
    output logic [15:0]      spi_address,
    output logic [DW-1:0]    spi_write_data,
    input  logic [DW-1:0]    spi_read_data,
    input  logic             spi_busy
);

    localparam int WAIT_MAX = (POWERUP_CYCLES > POLL_GAP_CYCLES) ? POWERUP_CYCLES : POLL_GAP_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int TMO_W    = $clog2(START_TIMEOUT + 1);
    localparam int RTY_W    = $clog2(LOCK_RETRIES + 1);
    localparam logic [DW-1:0] PLL_WORD = DW'(PLL_CONFIG) << (DW - 48);

    typedef enum logic [3:0] {
        S_POWERUP, S_LATCH, S_PLL_WR, S_PLL_RD, S_PLL_CHECK,
        S_PLL_GAP, S_TBL_FETCH, S_TBL_WR, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {X_ISSUE, X_WAIT_BUSY, X_WAIT_IDLE, X_GAP} xfer_t;

    state_t            state;
    xfer_t             xfer;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        gap_cnt;
    logic [1:0]        latch_cnt;
    logic [RTY_W-1:0]  retry_cnt;

    // Only the lock bit is consulted; the rest of the read word is intentionally ignored.
    logic unused_read_bits;
    assign unused_read_bits = ^spi_read_data;

    // NOTE: a single clocked process with non-blocking assignments; every output
    // is a register, so nothing combinational ever reaches the SPI engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_POWERUP;
            xfer           <= X_ISSUE;
            wait_cnt       <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            latch_cnt      <= '0;
            retry_cnt      <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'd0;
            tbl_index      <= '0;
            spi_start      <= 1'b0;
            spi_read       <= 1'b0;
            spi_nbytes     <= '0;
            spi_address    <= '0;
            spi_write_data <= '0;
        end else begin
            case (state)
                S_POWERUP: begin
                    latch_cnt <= '0;
                    retry_cnt <= '0;
                    xfer      <= X_ISSUE;
                    if (int'(wait_cnt) >= POWERUP_CYCLES - 1) begin
                        wait_cnt <= '0;
                        state    <= S_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_LATCH, S_PLL_WR, S_PLL_RD, S_TBL_WR: begin
                    case (xfer)
                        X_ISSUE: begin
                            spi_start <= 1'b1;
                            spi_read  <= (state == S_PLL_RD);
                            tmo_cnt   <= '0;
                            xfer      <= X_WAIT_BUSY;
                            case (state)
                                S_LATCH: begin
                                    spi_nbytes     <= NB_W'(1);
                                    spi_address    <= 16'h4000;
                                    spi_write_data <= '0;
                                end
                                S_PLL_WR, S_PLL_RD: begin
                                    spi_nbytes     <= NB_W'(6);
                                    spi_address    <= 16'h4002;
                                    spi_write_data <= (state == S_PLL_WR) ? PLL_WORD : '0;
                                end
                                default: begin
                                    spi_nbytes     <= NB_W'(1);
                                    spi_address    <= tbl_entry[23:8];
                                    spi_write_data <= DW'(tbl_entry[7:0]) << (DW - 8);
                                end
                            endcase
                        end
                        X_WAIT_BUSY: begin
                            if (spi_busy) begin
                                spi_start <= 1'b0;
                                xfer      <= X_WAIT_IDLE;
                            end else if (int'(tmo_cnt) >= START_TIMEOUT - 1) begin
                                spi_start <= 1'b0;
                                error     <= 1'b1;
                                err_code  <= 2'd2;
                                state     <= S_ERROR;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
                        X_WAIT_IDLE: begin
                            if (!spi_busy) begin
                                gap_cnt <= '0;
                                xfer    <= X_GAP;
                            end
                        end
                        default: begin
                            // The engine sees start through a 2-flop synchroniser; 4 low clocks are mandatory.
                            if (gap_cnt == 2'd3) begin
                                xfer <= X_ISSUE;
                                case (state)
                                    S_LATCH: begin
                                        if (latch_cnt == 2'd2) state <= S_PLL_WR;
                                        else                   latch_cnt <= latch_cnt + 1'b1;
                                    end
                                    S_PLL_WR: state <= S_PLL_RD;
                                    S_PLL_RD: begin
                                        retry_cnt <= retry_cnt + 1'b1;
                                        state     <= S_PLL_CHECK;
                                    end
                                    default: begin
                                        if (int'(tbl_index) == NUM_REGS - 1) begin
                                            done  <= 1'b1;
                                            state <= S_DONE;
                                        end else begin
                                            tbl_index <= tbl_index + 1'b1;
                                            state     <= S_TBL_FETCH;
                                        end
                                    end
                                endcase
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                    endcase
                end

                S_PLL_CHECK: begin
                    wait_cnt <= '0;
                    if (spi_read_data[PLL_LOCK_BIT]) begin
                        state <= S_TBL_FETCH;
                    end else if (int'(retry_cnt) >= LOCK_RETRIES) begin
                        error    <= 1'b1;
                        err_code <= 2'd1;
                        state    <= S_ERROR;
                    end else begin
                        state <= S_PLL_GAP;
                    end
                end

                S_PLL_GAP: begin
                    if (int'(wait_cnt) >= POLL_GAP_CYCLES - 1) state <= S_PLL_RD;
                    else                                       wait_cnt <= wait_cnt + 1'b1;
                end

                S_TBL_FETCH: begin
                    if (NUM_REGS == 0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_TBL_WR;
                    end
                end

                S_DONE, S_ERROR: begin
                    if (restart) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= 2'd0;
                        tbl_index <= '0;
                        wait_cnt  <= '0;
                        state     <= S_POWERUP;
                    end
                end

                default: state <= S_POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_adau1761_init_sequencer.sv
// Self-checking bench: randomized SPI engine and ROM models, transaction log
// compared against a transaction-list reference model of the bring-up sequence.
module tb_adau1761_init_sequencer;

    localparam int          MAX_BYTES       = 8;
    localparam int          POWERUP_CYCLES  = 100;
    localparam logic [47:0] PLL_CONFIG      = 48'h007D000C2301;
    localparam int          PLL_LOCK_BIT    = 1;
    localparam int          LOCK_RETRIES    = 4;
    localparam int          POLL_GAP_CYCLES = 20;
    localparam int          NUM_REGS        = 3;
    localparam int          START_TIMEOUT   = 16;
    localparam int          DW              = MAX_BYTES * 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic          done, error;
    logic [1:0]    err_code;
    logic [1:0]    tbl_index;
    logic [23:0]   tbl_entry = '0;
    logic          spi_start, spi_read;
    logic [2:0]    spi_nbytes;
    logic [15:0]   spi_address;
    logic [DW-1:0] spi_write_data;
    logic [DW-1:0] spi_read_data = '0;
    logic          spi_busy = 1'b0;

    adau1761_init_sequencer #(
        .MAX_BYTES(MAX_BYTES), .POWERUP_CYCLES(POWERUP_CYCLES), .PLL_CONFIG(PLL_CONFIG),
        .PLL_LOCK_BIT(PLL_LOCK_BIT), .LOCK_RETRIES(LOCK_RETRIES),
        .POLL_GAP_CYCLES(POLL_GAP_CYCLES), .NUM_REGS(NUM_REGS), .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .done(done), .error(error),
        .err_code(err_code), .tbl_index(tbl_index), .tbl_entry(tbl_entry),
        .spi_start(spi_start), .spi_read(spi_read), .spi_nbytes(spi_nbytes),
        .spi_address(spi_address), .spi_write_data(spi_write_data),
        .spi_read_data(spi_read_data), .spi_busy(spi_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rd;
        int            nbytes;
        logic [15:0]   addr;
        logic [DW-1:0] wdata;
        int            low;   // start-low clocks before this request
        int            idle;  // consecutive start-low and busy-low clocks before it
    } txn_t;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [23:0] rom [NUM_REGS];
    int          n_assert = 0;
    int          n_fail = 0;

    // Engine model controls
    bit dead = 1'b0;
    int lock_at = 1;
    int n_reads = 0;
    int last_high = 0;

    always @(posedge clk) tbl_entry <= rom[tbl_index];

    // SPI engine model: logs each start edge, answers with randomized busy timing.
    always @(negedge clk) begin : engine
        txn_t t;
        static int   pend = 0, blen = 0, low_run = 0, idle_run = 0, high_run = 0;
        static logic start_prev = 1'b0;
        if (reset) begin
            spi_busy   = 1'b0;
            pend       = 0;
            blen       = 0;
            low_run    = 0;
            idle_run   = 0;
            high_run   = 0;
            start_prev = 1'b0;
        end else begin
            if (spi_start && !start_prev) begin
                t.rd     = spi_read;
                t.nbytes = int'(spi_nbytes);
                t.addr   = spi_address;
                t.wdata  = spi_write_data;
                t.low    = low_run;
                t.idle   = idle_run;
                obs_q.push_back(t);
                low_run  = 0;
                idle_run = 0;
                high_run = 0;
                if (spi_read) begin
                    n_reads++;
                    spi_read_data = {$urandom, $urandom};
                    spi_read_data[PLL_LOCK_BIT] = (n_reads == lock_at);
                end
                if (!dead) pend = $urandom_range(1, 3);
            end
            if (!spi_start && start_prev) last_high = high_run;
            if (spi_start) high_run++;
            else           low_run++;
            if (!spi_start && !spi_busy) idle_run++;
            else                         idle_run = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    spi_busy = 1'b1;
                    blen     = $urandom_range(2, 6);
                end
            end else if (spi_busy) begin
                blen--;
                if (blen == 0) spi_busy = 1'b0;
            end
            start_prev = spi_start;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input bit rd, input int nb, input logic [15:0] addr, input logic [63:0] wd);
        txn_t t;
        t.rd = rd; t.nbytes = nb; t.addr = addr; t.wdata = wd; t.low = 0; t.idle = 0;
        exp_q.push_back(t);
    endtask

    // Reference model: the ordered list of SPI requests the sequence must produce.
    task automatic build_exp(input int lock, input bit no_engine);
        int  nrd;
        bit  locks;
        exp_q.delete();
        for (int i = 0; i < (no_engine ? 1 : 3); i++) push_exp(1'b0, 1, 16'h4000, 64'h0);
        if (no_engine) return;
        push_exp(1'b0, 6, 16'h4002, {PLL_CONFIG, 16'h0000});
        locks = (lock >= 1 && lock <= LOCK_RETRIES);
        nrd   = locks ? lock : LOCK_RETRIES;
        for (int i = 0; i < nrd; i++) push_exp(1'b1, 6, 16'h4002, 64'h0);
        if (locks)
            for (int i = 0; i < NUM_REGS; i++) push_exp(1'b0, 1, rom[i][23:8], {rom[i][7:0], 56'h0});
    endtask

    task automatic compare_run(input string tag);
        check({tag, "/txn_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s/t%0d.read", tag, i), obs_q[i].rd, exp_q[i].rd);
            check($sformatf("%s/t%0d.nbytes", tag, i), obs_q[i].nbytes, exp_q[i].nbytes);
            check($sformatf("%s/t%0d.addr", tag, i), obs_q[i].addr, exp_q[i].addr);
            if (!exp_q[i].rd)
                check($sformatf("%s/t%0d.wdata", tag, i), obs_q[i].wdata, exp_q[i].wdata);
            check($sformatf("%s/t%0d.gap_ge4", tag, i), obs_q[i].idle >= 4, 1);
            if (i == 0)
                check($sformatf("%s/t0.powerup_wait", tag), obs_q[i].low >= POWERUP_CYCLES, 1);
            if (i > 0 && exp_q[i].rd && exp_q[i-1].rd)
                check($sformatf("%s/t%0d.poll_gap", tag, i), obs_q[i].low >= POLL_GAP_CYCLES, 1);
        end
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "/finished"}, done || error, 1'b1);
    endtask

    task automatic start_case(input int lock, input bit no_engine);
        lock_at = lock;
        dead    = no_engine;
        n_reads = 0;
        obs_q.delete();
        for (int i = 0; i < NUM_REGS; i++) rom[i] = 24'($urandom);
        build_exp(lock, no_engine);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "/done"}, done, 1'b0);
        check({tag, "/error"}, error, 1'b0);
        check({tag, "/err_code"}, err_code, 2'd0);
        check({tag, "/spi_start"}, spi_start, 1'b0);
        check({tag, "/spi_read"}, spi_read, 1'b0);
        check({tag, "/spi_nbytes"}, spi_nbytes, 3'd0);
        check({tag, "/spi_address"}, spi_address, 16'h0);
        check({tag, "/spi_write_data"}, spi_write_data, 64'h0);
        check({tag, "/tbl_index"}, tbl_index, 2'd0);
    endtask

    initial begin
        int n;

        // Reset state
        for (int i = 0; i < NUM_REGS; i++) rom[i] = 24'($urandom);
        tick();
        tick();
        check_reset_values("reset");

        // Nominal: lock on the first read
        start_case(1, 1'b0);
        wait_end("nominal", 3000);
        compare_run("nominal");
        check("nominal/done", done, 1'b1);
        check("nominal/error", error, 1'b0);

        // Lock on the third read
        start_case(3, 1'b0);
        wait_end("lock3", 3000);
        compare_run("lock3");
        check("lock3/reads", n_reads, 3);
        check("lock3/done", done, 1'b1);

        // Lock never reported
        start_case(0, 1'b0);
        wait_end("nolock", 3000);
        compare_run("nolock");
        check("nolock/reads", n_reads, LOCK_RETRIES);
        check("nolock/error", error, 1'b1);
        check("nolock/err_code", err_code, 2'd1);
        check("nolock/done", done, 1'b0);

        // Engine never raises busy
        start_case(1, 1'b1);
        wait_end("timeout", 3000);
        compare_run("timeout");
        check("timeout/start_high", last_high, START_TIMEOUT);
        check("timeout/error", error, 1'b1);
        check("timeout/err_code", err_code, 2'd2);
        check("timeout/done", done, 1'b0);

        // Reset during table write 1
        start_case(1, 1'b0);
        n = 0;
        while (obs_q.size() < 7 && n < 3000) begin
            tick();
            n++;
        end
        check("midreset/reached_tbl1", obs_q.size(), 7);
        reset = 1'b1;
        tick();
        check_reset_values("midreset");
        obs_q.delete();
        n_reads = 0;
        build_exp(1, 1'b0);
        reset = 1'b0;
        wait_end("midreset", 3000);
        compare_run("midreset");
        check("midreset/done", done, 1'b1);

        // restart during PLL_GAP is ignored
        start_case(2, 1'b0);
        n = 0;
        while (n_reads < 1 && n < 3000) begin
            tick();
            n++;
        end
        check("restart_gap/first_read", n_reads, 1);
        repeat (20) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_end("restart_gap", 3000);
        compare_run("restart_gap");
        check("restart_gap/done", done, 1'b1);

        // restart in DONE reruns everything with a random lock position
        obs_q.delete();
        n_reads = 0;
        lock_at = $urandom_range(1, LOCK_RETRIES);
        build_exp(lock_at, 1'b0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_done/done_cleared", done, 1'b0);
        check("restart_done/tbl_index", tbl_index, 2'd0);
        wait_end("restart_done", 3000);
        compare_run("restart_done");
        check("restart_done/done", done, 1'b1);
        check("restart_done/error", error, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
